// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state type, default sizes and the zero data returned on an aborted access
package cpu_mem_pkg;
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} arb_state_t;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int MAX_D_STREAK_DEF = 4;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam logic [DW_DEF-1:0] ZERO_DATA = '0;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: clearable saturating cycle counter; expired marks the enabled cycle whose increment reaches limit
module mem_arb_timer #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != limit) cnt <= cnt + W'(1);
  assign expired = en && (cnt + W'(1) == limit);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between the fetch and load/store ports, with stall and timeout
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ready_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ready_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          stall_o,
  output logic          err_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  arb_state_t state, state_n;
  logic [SW-1:0] streak;
  logic streak_max, grant_i, grant_d, busy, expired, done;
  logic [DW-1:0] rdata;
  mem_arb_timer #(.W(TW)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (grant_i || grant_d),
    .en     (busy),
    .limit  (TW'(TIMEOUT_CYC)),
    .expired(expired)
  );
  always_comb begin
    streak_max = streak == SW'(MAX_D_STREAK);
    grant_i = state == IDLE && if_req_i && (streak_max || !d_req_i);
    grant_d = state == IDLE && d_req_i && !(if_req_i && streak_max);
    busy = state == BUSY_I || state == BUSY_D;
    done = busy && (mem_ack_i || expired);
    rdata = mem_ack_i ? mem_rdata_i : DW'(ZERO_DATA);
    state_n = state;
    case (state)
      IDLE:    state_n = grant_i ? BUSY_I : grant_d ? BUSY_D : IDLE;
      BUSY_I:  state_n = done ? RESP_I : BUSY_I;
      BUSY_D:  state_n = done ? RESP_D : BUSY_D;
      default: state_n = IDLE;
    endcase
  end
  assign stall_o = (if_req_i && !if_ready_o) || (d_req_i && !d_ready_o);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      streak <= '0;
      if_rdata_o <= '0;
      if_ready_o <= 1'b0;
      d_rdata_o <= '0;
      d_ready_o <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      if_ready_o <= state_n == RESP_I;
      d_ready_o <= state_n == RESP_D;
      if (grant_i || grant_d) begin
        mem_req_o <= 1'b1;
        mem_we_o <= grant_d && d_we_i;
        mem_addr_o <= grant_d ? d_addr_i : if_addr_i;
        mem_wdata_o <= grant_d ? d_wdata_i : '0;
      end
      if (done) begin
        mem_req_o <= 1'b0;
        err_o <= err_o || !mem_ack_i;
        if (state == BUSY_I) if_rdata_o <= rdata;
        else d_rdata_o <= rdata;
      end
      streak <= grant_i ? '0 :
                (grant_d && if_req_i && !streak_max) ? streak + SW'(1) :
                (state == IDLE && !if_req_i) ? '0 : streak;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for the fetch/data memory arbiter
module tb_mem_port_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic if_ready_o, d_ready_o, mem_req_o, mem_we_o, stall_o, err_o;
  typedef struct {logic [31:0] data; bit chk;} resp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; bit chk_wd;} gnt_t;
  resp_t if_q[$], d_q[$];
  gnt_t g_q[$];
  int n_chk = 0, n_fail = 0;
  int ack_cyc = 0, req_cyc = 0, last_req_len = 0;
  logic [31:0] rd_val = '0;
  always #5 clk_i = ~clk_i;
  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event expected one within budget", name);
  endtask
  task automatic exp_g(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit chk_wd);
    gnt_t g;
    g.we = we; g.addr = addr; g.wdata = wdata; g.chk_wd = chk_wd;
    g_q.push_back(g);
  endtask
  task automatic exp_r(input bit is_d, input logic [31:0] data, input bit c);
    resp_t r;
    r.data = data; r.chk = c;
    if (is_d) d_q.push_back(r);
    else if_q.push_back(r);
  endtask
  task automatic wait_sig(input int which, input int budget, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if ((which == 0 && if_ready_o) || (which == 1 && d_ready_o) || (which == 2 && mem_req_o)) return;
      if (cyc >= budget) begin
        fail_now(which == 0 ? "wait_if_ready" : which == 1 ? "wait_d_ready" : "wait_mem_req");
        return;
      end
    end
  endtask
  initial forever begin
    @(negedge clk_i);
    if (mem_req_o) begin
      req_cyc++;
      mem_ack_i = req_cyc == ack_cyc;
      mem_rdata_i = rd_val;
    end else begin
      if (req_cyc > 0) last_req_len = req_cyc;
      req_cyc = 0;
      mem_ack_i = 1'b0;
      mem_rdata_i = '0;
    end
  end
  initial begin : mon
    gnt_t g;
    resp_t r;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o && !prev_req) begin
        if (g_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_grant: got addr %h expected no grant", mem_addr_o);
        end else begin
          g = g_q.pop_front();
          chk("grant_we", 32'(mem_we_o), 32'(g.we));
          chk("grant_addr", mem_addr_o, g.addr);
          if (g.chk_wd) chk("grant_wdata", mem_wdata_o, g.wdata);
        end
      end
      prev_req = mem_req_o;
      if (if_ready_o) begin
        if (if_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_if_ready: got data %h expected no response", if_rdata_o);
        end else begin
          r = if_q.pop_front();
          if (r.chk) chk("if_rdata", if_rdata_o, r.data);
        end
      end
      if (d_ready_o) begin
        if (d_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_d_ready: got data %h expected no response", d_rdata_o);
        end else begin
          r = d_q.pop_front();
          if (r.chk) chk("d_rdata", d_rdata_o, r.data);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, nd, nf, nd_at_f;
    repeat (2) @(negedge clk_i);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_if_ready", 32'(if_ready_o), 0);
    chk("rst_d_ready", 32'(d_ready_o), 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    if_addr_i = 32'h10; rd_val = 32'h00500093; ack_cyc = 3;
    exp_g(1'b0, 32'h10, 32'h0, 1'b0);
    exp_r(1'b0, 32'h00500093, 1'b1);
    if_req_i = 1'b1;
    #1 chk("t1_stall_wait", 32'(stall_o), 1);
    wait_sig(2, 10, c);
    chk("t1_grant_lat", c, 1);
    chk("t1_stall_busy", 32'(stall_o), 1);
    wait_sig(0, 10, c);
    chk("t1_ready_lat", c, 3);
    chk("t1_stall_ready", 32'(stall_o), 0);
    if_req_i = 1'b0;
    @(negedge clk_i);
    rd_val = 32'h13; ack_cyc = 2;
    exp_g(1'b1, 32'h40, 32'hCAFE, 1'b1);
    exp_g(1'b0, 32'h20, 32'h0, 1'b0);
    exp_r(1'b1, 32'h0, 1'b0);
    exp_r(1'b0, 32'h13, 1'b1);
    if_addr_i = 32'h20; d_addr_i = 32'h40; d_we_i = 1'b1; d_wdata_i = 32'hCAFE;
    if_req_i = 1'b1; d_req_i = 1'b1;
    wait_sig(1, 20, c);
    chk("t2_store_lat", c, 3);
    d_req_i = 1'b0; d_we_i = 1'b0;
    wait_sig(2, 10, c);
    chk("t2_bubble", c, 2);
    wait_sig(0, 10, c);
    chk("t2_fetch_lat", c, 2);
    if_req_i = 1'b0;
    @(negedge clk_i);
    rd_val = 32'h55; ack_cyc = 1;
    if_addr_i = 32'h100; d_addr_i = 32'h80; d_wdata_i = 32'h0;
    for (int k = 0; k < 4; k++) exp_g(1'b0, 32'h80, 32'h0, 1'b0);
    exp_g(1'b0, 32'h100, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) exp_g(1'b0, 32'h80, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) exp_r(1'b1, 32'h55, 1'b1);
    exp_r(1'b0, 32'h55, 1'b1);
    if_req_i = 1'b1; d_req_i = 1'b1;
    nd = 0; nf = 0; nd_at_f = -1;
    for (int k = 0; k < 100 && nd < 6; k++) begin
      @(negedge clk_i);
      if (if_ready_o) begin
        if_req_i = 1'b0;
        nf++;
        nd_at_f = nd;
      end
      if (d_ready_o) begin
        nd++;
        if (nd == 6) d_req_i = 1'b0;
      end
    end
    chk("t3_data_count", nd, 6);
    chk("t3_fetch_count", nf, 1);
    chk("t3_fetch_after", nd_at_f, 4);
    @(negedge clk_i);
    chk("t4_err_before", 32'(err_o), 0);
    rd_val = 32'hDEAD; ack_cyc = 0; d_addr_i = 32'h200;
    exp_g(1'b0, 32'h200, 32'h0, 1'b0);
    exp_r(1'b1, 32'h0, 1'b1);
    d_req_i = 1'b1;
    wait_sig(1, 100, c);
    chk("t4_timeout_lat", c, 65);
    chk("t4_err_set", 32'(err_o), 1);
    d_req_i = 1'b0;
    @(negedge clk_i);
    chk("t4_req_len", last_req_len, 64);
    chk("t4_req_dropped", 32'(mem_req_o), 0);
    rd_val = 32'h1234; ack_cyc = 2; if_addr_i = 32'h300;
    exp_g(1'b0, 32'h300, 32'h0, 1'b0);
    exp_r(1'b0, 32'h1234, 1'b1);
    if_req_i = 1'b1;
    wait_sig(0, 20, c);
    chk("t4_after_lat", c, 3);
    if_req_i = 1'b0;
    @(negedge clk_i);
    chk("t4_err_sticky", 32'(err_o), 1);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("t5_err_cleared", 32'(err_o), 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rd_val = 32'hBEEF; ack_cyc = 64; d_addr_i = 32'h400;
    exp_g(1'b0, 32'h400, 32'h0, 1'b0);
    exp_r(1'b1, 32'hBEEF, 1'b1);
    d_req_i = 1'b1;
    wait_sig(1, 100, c);
    chk("t5_limit_ack_lat", c, 65);
    chk("t5_no_err", 32'(err_o), 0);
    d_req_i = 1'b0;
    @(negedge clk_i);
    rd_val = 32'h0; ack_cyc = 0; d_addr_i = 32'h500;
    exp_g(1'b0, 32'h500, 32'h0, 1'b0);
    d_req_i = 1'b1;
    wait_sig(2, 10, c);
    chk("t6_grant_lat", c, 1);
    repeat (4) @(negedge clk_i);
    chk("t6_req_before", 32'(mem_req_o), 1);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_async_mem_req", 32'(mem_req_o), 0);
    chk("t6_async_d_ready", 32'(d_ready_o), 0);
    chk("t6_async_if_ready", 32'(if_ready_o), 0);
    chk("t6_async_err", 32'(err_o), 0);
    chk("t6_stall_held", 32'(stall_o), 1);
    @(negedge clk_i);
    d_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rd_val = 32'h777; ack_cyc = 2; if_addr_i = 32'h600;
    exp_g(1'b0, 32'h600, 32'h0, 1'b0);
    exp_r(1'b0, 32'h777, 1'b1);
    if_req_i = 1'b1;
    wait_sig(2, 10, c);
    chk("t6_fetch_grant_lat", c, 1);
    wait_sig(0, 10, c);
    chk("t6_fetch_ready_lat", c, 2);
    if_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("end_grant_q", g_q.size(), 0);
    chk("end_if_q", if_q.size(), 0);
    chk("end_d_q", d_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
